// File: rtl/sid_voice_arbiter.sv
// rtl/sid_voice_arbiter.sv - shares one SID voice register set between two requesters
//
// Purpose:
//   Requester 0 (high priority) and requester 1 (low priority) each present a
//   voice bundle {frequency, duration, attack, sustain, waveform}. The arbiter
//   picks an owner and forwards that owner's bundle to the voice registers.
//   Whenever ownership changes, the gate (waveform bit0) is held low for at
//   least one cycle so that the voice ADSR retriggers. After the owner drops
//   its gate, the last bundle is held with gate=0 for a release tail.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req0_* / req1_*            requester bundles; reqN_valid qualifies them
//   frequency .. waveform      registered voice bundle (waveform bit0 = gate)
//   grant                      one-hot owner: 2'b10 = requester 0,
//                              2'b01 = requester 1, 2'b00 = none
//   busy                       high whenever the arbiter is not IDLE

module sid_voice_arbiter #(
  parameter int RELEASE_CYCLES = 262144,
  parameter int GAP_CYCLES     = 4,
  parameter int PREEMPT        = 1,
  parameter int CNT_W          = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_frequency,
  input  logic [7:0]  req0_duration,
  input  logic [7:0]  req0_attack,
  input  logic [7:0]  req0_sustain,
  input  logic [7:0]  req0_waveform,
  input  logic        req1_valid,
  input  logic [15:0] req1_frequency,
  input  logic [7:0]  req1_duration,
  input  logic [7:0]  req1_attack,
  input  logic [7:0]  req1_sustain,
  input  logic [7:0]  req1_waveform,
  output logic [15:0] frequency,
  output logic [7:0]  duration,
  output logic [7:0]  attack,
  output logic [7:0]  sustain,
  output logic [7:0]  waveform,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2,
    GAP     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] REL_LOAD = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  logic             owner;      // 0 = requester 0, 1 = requester 1
  logic [CNT_W-1:0] counter;
  logic [47:0]      voice_q;    // {frequency, duration, attack, sustain, waveform}

  logic        req0_act;
  logic        req1_act;
  logic        own_act;
  logic [47:0] bundle0;
  logic [47:0] bundle1;
  logic [47:0] own_bundle;
  logic [47:0] hold_gate_low;

  assign req0_act = req0_valid & req0_waveform[0];
  assign req1_act = req1_valid & req1_waveform[0];

  assign bundle0 = {req0_frequency, req0_duration, req0_attack, req0_sustain, req0_waveform};
  assign bundle1 = {req1_frequency, req1_duration, req1_attack, req1_sustain, req1_waveform};

  assign own_act       = owner ? req1_act : req0_act;
  assign own_bundle    = owner ? bundle1 : bundle0;
  assign hold_gate_low = {voice_q[47:1], 1'b0};

  assign {frequency, duration, attack, sustain, waveform} = voice_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= 1'b0;
      counter <= '0;
      voice_q <= '0;
      grant   <= 2'b00;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_act) begin
            state   <= OWN;
            owner   <= 1'b0;
            voice_q <= bundle0;
            grant   <= 2'b10;
            busy    <= 1'b1;
          end else if (req1_act) begin
            state   <= OWN;
            owner   <= 1'b1;
            voice_q <= bundle1;
            grant   <= 2'b01;
            busy    <= 1'b1;
          end else begin
            voice_q <= hold_gate_low;
            grant   <= 2'b00;
            busy    <= 1'b0;
          end
        end

        OWN: begin
          if (!own_act) begin
            // Owner release wins over a simultaneous preemption request.
            state   <= RELEASE;
            counter <= REL_LOAD;
            voice_q <= hold_gate_low;
            grant   <= 2'b00;
          end else if ((PREEMPT != 0) && owner && req0_act) begin
            state   <= GAP;
            counter <= GAP_LOAD;
            voice_q <= hold_gate_low;
            grant   <= 2'b00;
          end else begin
            // Field changes with gate still high are forwarded without retrigger.
            voice_q <= own_bundle;
            grant   <= owner ? 2'b01 : 2'b10;
          end
          busy <= 1'b1;
        end

        RELEASE: begin
          // Gate has already been low for a cycle, so a takeover retriggers.
          if (req0_act) begin
            state   <= OWN;
            owner   <= 1'b0;
            counter <= '0;
            voice_q <= bundle0;
            grant   <= 2'b10;
            busy    <= 1'b1;
          end else if (req1_act) begin
            state   <= OWN;
            owner   <= 1'b1;
            counter <= '0;
            voice_q <= bundle1;
            grant   <= 2'b01;
            busy    <= 1'b1;
          end else if (counter == '0) begin
            state   <= IDLE;
            voice_q <= hold_gate_low;
            grant   <= 2'b00;
            busy    <= 1'b0;
          end else begin
            counter <= counter - 1'b1;
            voice_q <= hold_gate_low;
            grant   <= 2'b00;
            busy    <= 1'b1;
          end
        end

        GAP: begin
          voice_q <= hold_gate_low;
          grant   <= 2'b00;
          busy    <= 1'b1;
          if (counter == '0) begin
            // Enter OWN with the gate still low; the bundle is loaded by OWN
            // on the following edge, which adds one more gate-low cycle.
            if (req0_act) begin
              state <= OWN;
              owner <= 1'b0;
            end else begin
              state   <= RELEASE;
              counter <= REL_LOAD;
            end
          end else begin
            counter <= counter - 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          voice_q <= hold_gate_low;
          grant   <= 2'b00;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sid_voice_arbiter.sv
// tb/tb_sid_voice_arbiter.sv - self-checking bench for sid_voice_arbiter

module tb_sid_voice_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic [15:0] req0_frequency;
  logic [7:0]  req0_duration;
  logic [7:0]  req0_attack;
  logic [7:0]  req0_sustain;
  logic [7:0]  req0_waveform;
  logic        req1_valid;
  logic [15:0] req1_frequency;
  logic [7:0]  req1_duration;
  logic [7:0]  req1_attack;
  logic [7:0]  req1_sustain;
  logic [7:0]  req1_waveform;

  logic [15:0] p_frequency, n_frequency;
  logic [7:0]  p_duration, n_duration;
  logic [7:0]  p_attack, n_attack;
  logic [7:0]  p_sustain, n_sustain;
  logic [7:0]  p_waveform, n_waveform;
  logic [1:0]  p_grant, n_grant;
  logic        p_busy, n_busy;

  int checks;
  int failures;

  sid_voice_arbiter #(
    .RELEASE_CYCLES(8), .GAP_CYCLES(2), .PREEMPT(1), .CNT_W(20)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_frequency(req0_frequency),
    .req0_duration(req0_duration), .req0_attack(req0_attack),
    .req0_sustain(req0_sustain), .req0_waveform(req0_waveform),
    .req1_valid(req1_valid), .req1_frequency(req1_frequency),
    .req1_duration(req1_duration), .req1_attack(req1_attack),
    .req1_sustain(req1_sustain), .req1_waveform(req1_waveform),
    .frequency(p_frequency), .duration(p_duration), .attack(p_attack),
    .sustain(p_sustain), .waveform(p_waveform), .grant(p_grant), .busy(p_busy)
  );

  sid_voice_arbiter #(
    .RELEASE_CYCLES(8), .GAP_CYCLES(2), .PREEMPT(0), .CNT_W(20)
  ) u_dut_np (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_frequency(req0_frequency),
    .req0_duration(req0_duration), .req0_attack(req0_attack),
    .req0_sustain(req0_sustain), .req0_waveform(req0_waveform),
    .req1_valid(req1_valid), .req1_frequency(req1_frequency),
    .req1_duration(req1_duration), .req1_attack(req1_attack),
    .req1_sustain(req1_sustain), .req1_waveform(req1_waveform),
    .frequency(n_frequency), .duration(n_duration), .attack(n_attack),
    .sustain(n_sustain), .waveform(n_waveform), .grant(n_grant), .busy(n_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        r0v;
    logic [15:0] r0f;
    logic [7:0]  r0w;
    logic        r1v;
    logic [15:0] r1f;
    logic [7:0]  r1w;
    logic [15:0] ef;   // preempting instance expectations
    logic [7:0]  ew;
    logic [1:0]  eg;
    logic        eb;
    logic [15:0] nf;   // non-preempting instance expectations
    logic [7:0]  nw;
    logic [1:0]  ng;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string name,
                              input logic r0v, input logic [15:0] r0f, input logic [7:0] r0w,
                              input logic r1v, input logic [15:0] r1f, input logic [7:0] r1w,
                              input logic [15:0] ef, input logic [7:0] ew, input logic [1:0] eg,
                              input logic eb,
                              input logic [15:0] nf, input logic [7:0] nw, input logic [1:0] ng);
    vec_t v;
    v.name = name;
    v.r0v = r0v; v.r0f = r0f; v.r0w = r0w;
    v.r1v = r1v; v.r1f = r1f; v.r1w = r1w;
    v.ef = ef; v.ew = ew; v.eg = eg; v.eb = eb;
    v.nf = nf; v.nw = nw; v.ng = ng;
    return v;
  endfunction

  initial begin
    int busy_cnt;
    int guard;
    checks   = 0;
    failures = 0;

    rst_n          = 1'b0;
    req0_valid     = 1'b0;
    req0_frequency = 16'd0;
    req0_duration  = 8'h10;
    req0_attack    = 8'h20;
    req0_sustain   = 8'h30;
    req0_waveform  = 8'h00;
    req1_valid     = 1'b0;
    req1_frequency = 16'd0;
    req1_duration  = 8'h41;
    req1_attack    = 8'h52;
    req1_sustain   = 8'h63;
    req1_waveform  = 8'h00;

    // Table: rows run back to back starting from IDLE.
    tbl.push_back(mk("both_same_cycle", 1,27,8'h11, 1,1678,8'h81, 27,8'h11,2'b10,1, 27,8'h11,2'b10));
    tbl.push_back(mk("req0_keeps",      1,27,8'h11, 1,1678,8'h81, 27,8'h11,2'b10,1, 27,8'h11,2'b10));
    tbl.push_back(mk("field_forward",   1,28,8'h11, 1,1678,8'h81, 28,8'h11,2'b10,1, 28,8'h11,2'b10));
    tbl.push_back(mk("drop_other_req",  1,28,8'h10, 1,1678,8'h81, 28,8'h10,2'b00,1, 28,8'h10,2'b00));
    tbl.push_back(mk("takeover_req1",   1,28,8'h10, 1,1678,8'h81, 1678,8'h81,2'b01,1, 1678,8'h81,2'b01));
    tbl.push_back(mk("preempt_gap1",    1,27,8'h11, 1,1678,8'h81, 1678,8'h80,2'b00,1, 1678,8'h81,2'b01));
    tbl.push_back(mk("preempt_gap2",    1,27,8'h11, 1,1678,8'h81, 1678,8'h80,2'b00,1, 1678,8'h81,2'b01));
    tbl.push_back(mk("preempt_gap3",    1,27,8'h11, 1,1678,8'h81, 1678,8'h80,2'b00,1, 1678,8'h81,2'b01));
    tbl.push_back(mk("preempt_own",     1,27,8'h11, 1,1678,8'h81, 27,8'h11,2'b10,1, 1678,8'h81,2'b01));
    tbl.push_back(mk("req1_release",    1,27,8'h11, 1,1678,8'h80, 27,8'h11,2'b10,1, 1678,8'h80,2'b00));
    tbl.push_back(mk("np_takeover",     1,27,8'h11, 1,1678,8'h80, 27,8'h11,2'b10,1, 27,8'h11,2'b10));
    tbl.push_back(mk("release_both",    1,27,8'h10, 1,1678,8'h80, 27,8'h10,2'b00,1, 27,8'h10,2'b00));
    tbl.push_back(mk("tail_cnt6",       0,0,8'h00,  1,1678,8'h80, 27,8'h10,2'b00,1, 27,8'h10,2'b00));
    tbl.push_back(mk("tail_cnt5",       0,0,8'h00,  1,1678,8'h80, 27,8'h10,2'b00,1, 27,8'h10,2'b00));
    tbl.push_back(mk("release_take",    0,0,8'h00,  1,1678,8'h81, 1678,8'h81,2'b01,1, 1678,8'h81,2'b01));

    // Reset state
    repeat (2) step();
    chk("rst_frequency", {16'd0, p_frequency}, 32'd0);
    chk("rst_waveform",  {24'd0, p_waveform}, 32'd0);
    chk("rst_grant",     {30'd0, p_grant}, 32'd0);
    chk("rst_busy",      {31'd0, p_busy}, 32'd0);
    chk("rst_np_grant",  {30'd0, n_grant}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", {31'd0, p_busy}, 32'd0);

    // req1 takes the voice from IDLE
    req1_valid     = 1'b1;
    req1_frequency = 16'd1678;
    req1_waveform  = 8'h81;
    step();
    chk("r1_frequency", {16'd0, p_frequency}, 32'd1678);
    chk("r1_waveform",  {24'd0, p_waveform}, 32'h81);
    chk("r1_grant",     {30'd0, p_grant}, 32'b01);
    chk("r1_misc", {8'd0, p_duration, p_attack, p_sustain}, {8'd0, 8'h41, 8'h52, 8'h63});

    // req1 drops its gate: release tail, busy counted from the owning cycle
    req1_waveform = 8'h80;
    busy_cnt = 0;
    guard    = 0;
    while (p_busy && guard < 30) begin
      busy_cnt++;
      step();
      guard++;
      if (guard == 1) begin
        chk("rel_waveform", {24'd0, p_waveform}, 32'h80);
        chk("rel_grant",    {30'd0, p_grant}, 32'b00);
      end
    end
    chk("rel_busy_cycles", busy_cnt, 32'd9);
    chk("rel_idle_freq", {16'd0, p_frequency}, 32'd1678);

    // Table-driven sequence
    foreach (tbl[i]) begin
      req0_valid     = tbl[i].r0v;
      req0_frequency = tbl[i].r0f;
      req0_waveform  = tbl[i].r0w;
      req1_valid     = tbl[i].r1v;
      req1_frequency = tbl[i].r1f;
      req1_waveform  = tbl[i].r1w;
      step();
      chk({tbl[i].name, "_freq"},    {16'd0, p_frequency}, {16'd0, tbl[i].ef});
      chk({tbl[i].name, "_wave"},    {24'd0, p_waveform}, {24'd0, tbl[i].ew});
      chk({tbl[i].name, "_grant"},   {30'd0, p_grant}, {30'd0, tbl[i].eg});
      chk({tbl[i].name, "_busy"},    {31'd0, p_busy}, {31'd0, tbl[i].eb});
      chk({tbl[i].name, "_npfreq"},  {16'd0, n_frequency}, {16'd0, tbl[i].nf});
      chk({tbl[i].name, "_npwave"},  {24'd0, n_waveform}, {24'd0, tbl[i].nw});
      chk({tbl[i].name, "_npgrant"}, {30'd0, n_grant}, {30'd0, tbl[i].ng});
    end
    chk("take_misc", {8'd0, p_duration, p_attack, p_sustain}, {8'd0, 8'h41, 8'h52, 8'h63});

    // Asynchronous reset in the middle of RELEASE
    req1_waveform = 8'h80;
    step();
    chk("pre_rst_wave", {24'd0, p_waveform}, 32'h80);
    chk("pre_rst_busy", {31'd0, p_busy}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_freq",  {16'd0, p_frequency}, 32'd0);
    chk("async_rst_misc",  {8'd0, p_duration, p_attack, p_sustain}, 32'd0);
    chk("async_rst_grant", {30'd0, p_grant}, 32'd0);
    chk("async_rst_busy",  {31'd0, p_busy}, 32'd0);
    chk("async_rst_npfreq", {16'd0, n_frequency}, 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    chk("post_rst_busy", {31'd0, p_busy}, 32'd0);
    chk("post_rst_wave", {24'd0, p_waveform}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sid_voice_arbiter.md
Name: sid_voice_arbiter

Overview:
- Shares one SID voice register set between two requesters:
  - requester 0: high priority, e.g. the drum sequencer;
  - requester 1: low priority, e.g. the SPI/host register path.
- Sits between the requesters and the voice inputs (frequency/duration/attack/sustain/waveform).
- Guarantees a gate-low interval between owners, so the voice ADSR always retriggers.
- Holds a release tail after the owner's gate drops.

Parameters:
- RELEASE_CYCLES, 262144: cycles the last bundle is held with gate=0 after the owner releases (~5.2 ms at 50 MHz); legal range 1..2^CNT_W.
- GAP_CYCLES, 4: forced gate-low cycles on preemption; legal range 1..2^CNT_W.
- PREEMPT, 1: 1 lets requester 0 preempt requester 1; 0 means no preemption.
- CNT_W, 20: width of the tail/gap counter.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- req0_valid, input, 1: requester 0 presents a bundle.
- req0_frequency, input, 16: requester 0 frequency.
- req0_duration, input, 8: requester 0 duration.
- req0_attack, input, 8: requester 0 attack/decay.
- req0_sustain, input, 8: requester 0 sustain/release.
- req0_waveform, input, 8: requester 0 waveform; bit0 = gate.
- req1_valid, req1_frequency, req1_duration, req1_attack, req1_sustain, req1_waveform: input; widths 1/16/8/8/8/8; same meanings for requester 1.
- frequency, output, 16: registered voice frequency.
- duration, output, 8: registered voice duration.
- attack, output, 8: registered voice attack/decay.
- sustain, output, 8: registered voice sustain/release.
- waveform, output, 8: registered voice waveform; bit0 = gate.
- grant, output, 2: one-hot current owner; 00 when no owner.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous, active-low. Assertion at any time, including mid-OWN/RELEASE/GAP, clears every register immediately.
- Reset values: all outputs 0, state IDLE, counter 0.
- Active request: reqN_act = reqN_valid & reqN_waveform[0].
- All outputs are registered. An input bundle change appears on the outputs 1 cycle later.
- "Hold, gate cleared" means waveform <= {waveform[7:1],1'b0}; the other fields keep their registered values.

IDLE:
- Outputs hold their last values with gate=0.
- If req0_act: state OWN, owner 0. Else if req1_act: state OWN, owner 1.
- On entering OWN, the owner's bundle is registered the same edge.
- Both active in the same cycle: requester 0 wins.

OWN:
- Each cycle, outputs <= owner bundle; grant = one-hot(owner).
- If the owner's reqN_act is 0 (valid dropped or gate cleared):
  - hold, gate cleared;
  - counter <= RELEASE_CYCLES-1;
  - state RELEASE.
- Else if PREEMPT=1, owner=1 and req0_act:
  - hold, gate cleared;
  - counter <= GAP_CYCLES-1;
  - state GAP.
- Owner release has priority over preemption in the same cycle.

RELEASE:
- Outputs held with gate=0; grant=00; busy=1.
- If req0_act, else req1_act: state OWN with that owner; bundle registered that edge.
- This takeover is legal because gate has been low for at least 1 cycle.
- Else if counter==0: state IDLE. Else counter decrements.
- Owner drops and the other requester asserts in the same OWN cycle: enter RELEASE first (1 gate-low cycle), take over on the next edge.

GAP:
- Outputs held with gate=0; grant=00; busy=1; counter decrements.
- Requests are ignored until counter==0.
- At counter==0: if req0_act, state OWN, owner 0. Else state RELEASE with counter <= RELEASE_CYCLES-1.

General rules:
- The counter decrements by 1 per cycle and never wraps below 0.
- A bundle field change while gate stays high is forwarded with no retrigger.
- Requester 1 is never preempted when PREEMPT=0. Requester 0 is never preempted.

Test Plan (bench parameters: RELEASE_CYCLES=8, GAP_CYCLES=2):
- Reset → all outputs 0, grant=00, busy=0. Pulse rst_n low mid-RELEASE → outputs 0 immediately, before any clk edge.
- From IDLE, req1 drives freq=1678, wave=0x81 → 1 cycle later frequency=1678, waveform=0x81, grant=01. Then req1 wave=0x80 → next cycle waveform=0x80, grant=00, busy held exactly 9 cycles, then IDLE.
- req0 (freq=27, wave=0x11) and req1 asserted in the same cycle from IDLE → grant=10, frequency=27.
- PREEMPT=1, req1 owns, req0 asserts wave=0x11 → waveform gate=0 for exactly 3 cycles, then frequency=27, waveform=0x11, grant=10.
- PREEMPT=0, same stimulus → req1 keeps the voice. After req1 releases: 1 gate-low cycle, then grant=10.
- During RELEASE (counter=5), req1 asserts → next edge grant=01 with req1's bundle; counter discarded.
